// File: rtl/conv_tile_scheduler.sv
// Multi-tile convolution sequencer: loops IFM tiles and output-channel groups around a
// single-tile engine, issuing IFM/WGT reads, conv starts and OFM writes with computed addresses.
module conv_tile_scheduler #(
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter int unsigned IFM_TILE_BYTES  = 491520,
  parameter int unsigned WGT_GROUP_BYTES = 9216,
  parameter int unsigned OFM_TILE_BYTES  = 28672,
  parameter bit          PREFETCH        = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_start,
  input  logic [CNT_WIDTH-1:0]  cfg_num_tiles,
  input  logic [CNT_WIDTH-1:0]  cfg_co_groups,
  input  logic [ADDR_WIDTH-1:0] ifm_base,
  input  logic [ADDR_WIDTH-1:0] wgt_base,
  input  logic [ADDR_WIDTH-1:0] ofm_base,
  output logic                  ifm_req,
  output logic [ADDR_WIDTH-1:0] ifm_addr,
  input  logic                  ifm_done,
  output logic                  wgt_req,
  output logic [ADDR_WIDTH-1:0] wgt_addr,
  input  logic                  wgt_done,
  input  logic                  ifm_buf_rdy,
  input  logic                  wgt_rdy,
  output logic                  start_conv,
  input  logic                  end_conv,
  output logic                  ofm_req,
  output logic [ADDR_WIDTH-1:0] ofm_addr,
  input  logic                  ofm_done,
  output logic                  busy,
  output logic                  op_done,
  output logic [CNT_WIDTH-1:0]  tile_idx,
  output logic [CNT_WIDTH-1:0]  grp_idx
);

  typedef enum logic [3:0] {
    StIdle, StWgtFetch, StIfmFetch, StWaitRdy, StStart, StCompute, StWrite, StNext, StFinish
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] IfmStride = ADDR_WIDTH'(IFM_TILE_BYTES);
  localparam logic [ADDR_WIDTH-1:0] WgtStride = ADDR_WIDTH'(WGT_GROUP_BYTES);
  localparam logic [ADDR_WIDTH-1:0] OfmStride = ADDR_WIDTH'(OFM_TILE_BYTES);

  function automatic logic [ADDR_WIDTH-1:0] widen(input logic [CNT_WIDTH-1:0] v);
    return ADDR_WIDTH'(v);
  endfunction

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  num_tiles_q, num_tiles_d, co_groups_q, co_groups_d;
  logic [CNT_WIDTH-1:0]  tile_q, tile_d, grp_q, grp_d;
  logic [ADDR_WIDTH-1:0] ifm_base_q, ifm_base_d, wgt_base_q, wgt_base_d, ofm_base_q, ofm_base_d;
  logic [ADDR_WIDTH-1:0] ifm_addr_q, ifm_addr_d, wgt_addr_q, wgt_addr_d, ofm_addr_q, ofm_addr_d;
  logic                  ifm_req_q, ifm_req_d, wgt_req_q, wgt_req_d, ofm_req_q, ofm_req_d;
  logic                  start_conv_q, start_conv_d, busy_q, busy_d, op_done_q, op_done_d;
  logic                  pf_done_q, pf_done_d;

  logic [CNT_WIDTH:0]    tile_inc, grp_inc;
  logic                  more_tiles, more_grps;
  logic                  ifm_fin, wgt_fin, ofm_fin;
  logic [ADDR_WIDTH-1:0] ifm_next_addr, wgt_next_addr, ofm_cur_addr;

  assign tile_inc   = {1'b0, tile_q} + (CNT_WIDTH+1)'(1);
  assign grp_inc    = {1'b0, grp_q} + (CNT_WIDTH+1)'(1);
  assign more_tiles = tile_inc < {1'b0, num_tiles_q};
  assign more_grps  = grp_inc < {1'b0, co_groups_q};
  // A done only counts while its own request is outstanding.
  assign ifm_fin    = ifm_req_q & ifm_done;
  assign wgt_fin    = wgt_req_q & wgt_done;
  assign ofm_fin    = ofm_req_q & ofm_done;

  assign ifm_next_addr = ifm_base_q + widen(tile_inc[CNT_WIDTH-1:0]) * IfmStride;
  assign wgt_next_addr = wgt_base_q + widen(grp_inc[CNT_WIDTH-1:0]) * WgtStride;
  assign ofm_cur_addr  = ofm_base_q + (widen(grp_q) * widen(num_tiles_q) + widen(tile_q)) * OfmStride;

  always_comb begin
    state_d      = state_q;
    num_tiles_d  = num_tiles_q;
    co_groups_d  = co_groups_q;
    ifm_base_d   = ifm_base_q;
    wgt_base_d   = wgt_base_q;
    ofm_base_d   = ofm_base_q;
    tile_d       = tile_q;
    grp_d        = grp_q;
    ifm_addr_d   = ifm_addr_q;
    wgt_addr_d   = wgt_addr_q;
    ofm_addr_d   = ofm_addr_q;
    ifm_req_d    = ifm_req_q & ~ifm_done;
    wgt_req_d    = wgt_req_q & ~wgt_done;
    ofm_req_d    = ofm_req_q & ~ofm_done;
    start_conv_d = 1'b0;
    op_done_d    = 1'b0;
    busy_d       = busy_q;
    pf_done_d    = pf_done_q;

    unique case (state_q)
      StIdle: begin
        // The cycle carrying the previous job's op_done never accepts a new start.
        if (op_start && !op_done_q) begin
          if (cfg_num_tiles == '0 || cfg_co_groups == '0) begin
            state_d = StFinish;
          end else begin
            num_tiles_d = cfg_num_tiles;
            co_groups_d = cfg_co_groups;
            ifm_base_d  = ifm_base;
            wgt_base_d  = wgt_base;
            ofm_base_d  = ofm_base;
            tile_d      = '0;
            grp_d       = '0;
            pf_done_d   = 1'b0;
            busy_d      = 1'b1;
            ifm_req_d   = 1'b1;
            ifm_addr_d  = ifm_base;
            wgt_req_d   = 1'b1;
            wgt_addr_d  = wgt_base;
            state_d     = StWgtFetch;
          end
        end
      end
      StWgtFetch: begin
        if ((!wgt_req_q || wgt_done) && (!ifm_req_q || ifm_done)) state_d = StWaitRdy;
      end
      StIfmFetch: begin
        if (ifm_fin) state_d = StWaitRdy;
      end
      StWaitRdy: begin
        if (ifm_buf_rdy && wgt_rdy) begin
          start_conv_d = 1'b1;
          state_d      = StStart;
        end
      end
      StStart: begin
        state_d = StCompute;
        if (PREFETCH && more_tiles) begin
          ifm_req_d  = 1'b1;
          ifm_addr_d = ifm_next_addr;
        end
      end
      StCompute: begin
        if (ifm_fin) pf_done_d = 1'b1;
        if (end_conv) begin
          ofm_req_d  = 1'b1;
          ofm_addr_d = ofm_cur_addr;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        if (ifm_fin) pf_done_d = 1'b1;
        if (ofm_fin) state_d = StNext;
      end
      StNext: begin
        if (more_tiles) begin
          if (pf_done_q || ifm_fin) begin
            tile_d    = tile_inc[CNT_WIDTH-1:0];
            pf_done_d = 1'b0;
            state_d   = StWaitRdy;
          end else if (!ifm_req_q) begin
            tile_d     = tile_inc[CNT_WIDTH-1:0];
            ifm_req_d  = 1'b1;
            ifm_addr_d = ifm_next_addr;
            state_d    = StIfmFetch;
          end
        end else if (more_grps) begin
          tile_d     = '0;
          grp_d      = grp_inc[CNT_WIDTH-1:0];
          wgt_req_d  = 1'b1;
          wgt_addr_d = wgt_next_addr;
          ifm_req_d  = 1'b1;
          ifm_addr_d = ifm_base_q;
          state_d    = StWgtFetch;
        end else begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        op_done_d = 1'b1;
        busy_d    = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      num_tiles_q  <= '0;
      co_groups_q  <= '0;
      ifm_base_q   <= '0;
      wgt_base_q   <= '0;
      ofm_base_q   <= '0;
      tile_q       <= '0;
      grp_q        <= '0;
      ifm_addr_q   <= '0;
      wgt_addr_q   <= '0;
      ofm_addr_q   <= '0;
      ifm_req_q    <= 1'b0;
      wgt_req_q    <= 1'b0;
      ofm_req_q    <= 1'b0;
      start_conv_q <= 1'b0;
      op_done_q    <= 1'b0;
      busy_q       <= 1'b0;
      pf_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_tiles_q  <= num_tiles_d;
      co_groups_q  <= co_groups_d;
      ifm_base_q   <= ifm_base_d;
      wgt_base_q   <= wgt_base_d;
      ofm_base_q   <= ofm_base_d;
      tile_q       <= tile_d;
      grp_q        <= grp_d;
      ifm_addr_q   <= ifm_addr_d;
      wgt_addr_q   <= wgt_addr_d;
      ofm_addr_q   <= ofm_addr_d;
      ifm_req_q    <= ifm_req_d;
      wgt_req_q    <= wgt_req_d;
      ofm_req_q    <= ofm_req_d;
      start_conv_q <= start_conv_d;
      op_done_q    <= op_done_d;
      busy_q       <= busy_d;
      pf_done_q    <= pf_done_d;
    end
  end

  assign ifm_req    = ifm_req_q;
  assign ifm_addr   = ifm_addr_q;
  assign wgt_req    = wgt_req_q;
  assign wgt_addr   = wgt_addr_q;
  assign ofm_req    = ofm_req_q;
  assign ofm_addr   = ofm_addr_q;
  assign start_conv = start_conv_q;
  assign busy       = busy_q;
  assign op_done    = op_done_q;
  assign tile_idx   = tile_q;
  assign grp_idx    = grp_q;

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Bench for conv_tile_scheduler: a PREFETCH=0 and a PREFETCH=1 instance side by side, each
// with randomised memory/conv responders, checked against the job's expected transfer list.
module tb_conv_tile_scheduler;
  localparam int unsigned AW = 64;
  localparam int unsigned CW = 16;
  localparam logic [63:0] IFM_B = 64'd491520;
  localparam logic [63:0] WGT_B = 64'd9216;
  localparam logic [63:0] OFM_B = 64'd28672;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [CW-1:0] cfg_num_tiles, cfg_co_groups;
  logic [AW-1:0] ifm_base, wgt_base, ofm_base;
  logic op_start [2];
  logic ifm_done [2];
  logic wgt_done [2];
  logic ofm_done [2];
  logic ifm_buf_rdy [2];
  logic wgt_rdy [2];
  logic end_conv [2];
  logic ifm_req [2];
  logic wgt_req [2];
  logic ofm_req [2];
  logic start_conv [2];
  logic busy [2];
  logic op_done [2];
  logic [AW-1:0] ifm_addr [2];
  logic [AW-1:0] wgt_addr [2];
  logic [AW-1:0] ofm_addr [2];
  logic [CW-1:0] tile_idx [2];
  logic [CW-1:0] grp_idx [2];

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  // Per-instance bookkeeping for the job in flight; index 1 is the prefetching instance.
  int unsigned n_ifm [2];
  int unsigned n_wgt [2];
  int unsigned n_ofm [2];
  int unsigned n_start [2];
  bit fin [2];
  bit conv_wait [2];
  bit in_comp [2];
  bit pf_chk [2];
  bit pf_exp [2];
  bit prev_start [2];
  bit rdy_last [2];
  bit hold_ifm [2];
  bit hold_wgt [2];
  bit hold_ofm [2];
  bit coll_chk [2];

  conv_tile_scheduler #(.PREFETCH(1'b0)) u_dut_nopf (
    .clk(clk), .rst_n(rst_n), .op_start(op_start[0]),
    .cfg_num_tiles(cfg_num_tiles), .cfg_co_groups(cfg_co_groups),
    .ifm_base(ifm_base), .wgt_base(wgt_base), .ofm_base(ofm_base),
    .ifm_req(ifm_req[0]), .ifm_addr(ifm_addr[0]), .ifm_done(ifm_done[0]),
    .wgt_req(wgt_req[0]), .wgt_addr(wgt_addr[0]), .wgt_done(wgt_done[0]),
    .ifm_buf_rdy(ifm_buf_rdy[0]), .wgt_rdy(wgt_rdy[0]),
    .start_conv(start_conv[0]), .end_conv(end_conv[0]),
    .ofm_req(ofm_req[0]), .ofm_addr(ofm_addr[0]), .ofm_done(ofm_done[0]),
    .busy(busy[0]), .op_done(op_done[0]), .tile_idx(tile_idx[0]), .grp_idx(grp_idx[0])
  );

  conv_tile_scheduler #(.PREFETCH(1'b1)) u_dut_pf (
    .clk(clk), .rst_n(rst_n), .op_start(op_start[1]),
    .cfg_num_tiles(cfg_num_tiles), .cfg_co_groups(cfg_co_groups),
    .ifm_base(ifm_base), .wgt_base(wgt_base), .ofm_base(ofm_base),
    .ifm_req(ifm_req[1]), .ifm_addr(ifm_addr[1]), .ifm_done(ifm_done[1]),
    .wgt_req(wgt_req[1]), .wgt_addr(wgt_addr[1]), .wgt_done(wgt_done[1]),
    .ifm_buf_rdy(ifm_buf_rdy[1]), .wgt_rdy(wgt_rdy[1]),
    .start_conv(start_conv[1]), .end_conv(end_conv[1]),
    .ofm_req(ofm_req[1]), .ofm_addr(ofm_addr[1]), .ofm_done(ofm_done[1]),
    .busy(busy[1]), .op_done(op_done[1]), .tile_idx(tile_idx[1]), .grp_idx(grp_idx[1])
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1);
  end

  task automatic clear_inputs;
    for (int i = 0; i < 2; i++) begin
      op_start[i] = 1'b0; ifm_done[i] = 1'b0; wgt_done[i] = 1'b0; ofm_done[i] = 1'b0;
      ifm_buf_rdy[i] = 1'b0; wgt_rdy[i] = 1'b0; end_conv[i] = 1'b0;
    end
  endtask

  // One negedge worth of responder activity and checks for instance i.
  task automatic step_dut(input string name, input int i, input int unsigned nt,
                          input int unsigned ng, input logic [63:0] ib, input logic [63:0] wb,
                          input logic [63:0] ob, input bit fast, input bit poke);
    int unsigned tot = nt * ng;
    bit ifm_gave, wgt_gave, ofm_gave;
    logic [63:0] exp;
    if (hold_ifm[i]) begin
      n_cmp++;
      if (ifm_req[i] !== 1'b1) begin
        n_fail++; $display("FAIL %s dut%0d ifm_req_hold: got %b required 1", name, i, ifm_req[i]);
      end
    end
    if (hold_wgt[i]) begin
      n_cmp++;
      if (wgt_req[i] !== 1'b1) begin
        n_fail++; $display("FAIL %s dut%0d wgt_req_hold: got %b required 1", name, i, wgt_req[i]);
      end
    end
    if (hold_ofm[i]) begin
      n_cmp++;
      if (ofm_req[i] !== 1'b1) begin
        n_fail++; $display("FAIL %s dut%0d ofm_req_hold: got %b required 1", name, i, ofm_req[i]);
      end
    end
    ifm_gave = ifm_done[i]; wgt_gave = wgt_done[i]; ofm_gave = ofm_done[i];
    ifm_done[i] = 1'b0; wgt_done[i] = 1'b0; ofm_done[i] = 1'b0;
    if (ifm_gave && wgt_gave) begin
      n_cmp++;
      if ({ifm_req[i], wgt_req[i]} !== 2'b00) begin
        n_fail++;
        $display("FAIL %s dut%0d both_drop: got ifm/wgt req %b%b required 00", name, i,
                 ifm_req[i], wgt_req[i]);
      end
    end
    if (pf_chk[i]) begin
      n_cmp++;
      if (ifm_req[i] !== pf_exp[i]) begin
        n_fail++;
        $display("FAIL %s dut%0d prefetch_req: got %b required %b", name, i, ifm_req[i], pf_exp[i]);
      end
      pf_chk[i] = 1'b0;
    end else if (i == 0 && in_comp[0]) begin
      n_cmp++;
      if (ifm_req[0] !== 1'b0) begin
        n_fail++; $display("FAIL %s dut0 nopf_compute_req: got %b required 0", name, ifm_req[0]);
      end
    end
    end_conv[i] = 1'b0;
    if (conv_wait[i] && (fast || $urandom_range(3) == 0)) begin
      end_conv[i] = 1'b1;
      conv_wait[i] = 1'b0;
    end
    if (start_conv[i]) begin
      n_cmp++;
      if (prev_start[i] !== 1'b0) begin
        n_fail++; $display("FAIL %s dut%0d start_width: got 2+ cycles required 1", name, i);
      end
      n_cmp++;
      if (rdy_last[i] !== 1'b1) begin
        n_fail++; $display("FAIL %s dut%0d start_rdy: got rdy %b required 1", name, i, rdy_last[i]);
      end
      n_cmp++;
      if ({grp_idx[i], tile_idx[i]} !== {CW'(n_start[i] / nt), CW'(n_start[i] % nt)}) begin
        n_fail++;
        $display("FAIL %s dut%0d indices: got g%0d t%0d required g%0d t%0d", name, i, grp_idx[i],
                 tile_idx[i], n_start[i] / nt, n_start[i] % nt);
      end
      pf_chk[i] = 1'b1;
      pf_exp[i] = (i == 1) && ((n_start[i] % nt) + 1 < nt);
      in_comp[i] = 1'b1;
      conv_wait[i] = 1'b1;
      n_start[i]++;
    end
    prev_start[i] = start_conv[i];
    ifm_buf_rdy[i] = fast || ($urandom_range(3) != 0);
    wgt_rdy[i] = fast || ($urandom_range(3) != 0);
    rdy_last[i] = ifm_buf_rdy[i] && wgt_rdy[i];
    if (!ifm_gave && ifm_req[i] && (fast || $urandom_range(2) == 0)) begin
      exp = ib + 64'(n_ifm[i] % nt) * IFM_B;
      n_cmp++;
      if (n_ifm[i] >= tot || ifm_addr[i] !== exp) begin
        n_fail++;
        $display("FAIL %s dut%0d ifm_xfer%0d: got %h required %h (of %0d)", name, i, n_ifm[i],
                 ifm_addr[i], exp, tot);
      end
      n_ifm[i]++;
      ifm_done[i] = 1'b1;
    end
    if (!wgt_gave && wgt_req[i] && (fast || $urandom_range(2) == 0)) begin
      exp = wb + 64'(n_wgt[i]) * WGT_B;
      n_cmp++;
      if (n_wgt[i] >= ng || wgt_addr[i] !== exp) begin
        n_fail++;
        $display("FAIL %s dut%0d wgt_xfer%0d: got %h required %h (of %0d)", name, i, n_wgt[i],
                 wgt_addr[i], exp, ng);
      end
      n_wgt[i]++;
      wgt_done[i] = 1'b1;
    end
    if (!ofm_gave && ofm_req[i] && (fast || $urandom_range(2) == 0)) begin
      exp = ob + 64'(n_ofm[i]) * OFM_B;
      n_cmp++;
      if (n_ofm[i] >= tot || ofm_addr[i] !== exp) begin
        n_fail++;
        $display("FAIL %s dut%0d ofm_xfer%0d: got %h required %h (of %0d)", name, i, n_ofm[i],
                 ofm_addr[i], exp, tot);
      end
      n_ofm[i]++;
      ofm_done[i] = 1'b1;
      in_comp[i] = 1'b0;
    end
    hold_ifm[i] = ifm_req[i] && !ifm_done[i];
    hold_wgt[i] = wgt_req[i] && !wgt_done[i];
    hold_ofm[i] = ofm_req[i] && !ofm_done[i];
    if (op_done[i]) begin
      n_cmp++;
      if (busy[i] !== 1'b0) begin
        n_fail++; $display("FAIL %s dut%0d busy_at_done: got %b required 0", name, i, busy[i]);
      end
      n_cmp++;
      if ({n_ifm[i], n_wgt[i], n_ofm[i], n_start[i]} !== {tot, ng, tot, tot}) begin
        n_fail++;
        $display("FAIL %s dut%0d counts: got ifm%0d wgt%0d ofm%0d conv%0d required %0d/%0d/%0d/%0d",
                 name, i, n_ifm[i], n_wgt[i], n_ofm[i], n_start[i], tot, ng, tot, tot);
      end
      fin[i] = 1'b1;
      if (poke) begin
        op_start[i] = 1'b1;
        coll_chk[i] = 1'b1;
      end
    end else begin
      n_cmp++;
      if (busy[i] !== 1'b1) begin
        n_fail++; $display("FAIL %s dut%0d busy: got %b required 1", name, i, busy[i]);
      end
    end
  endtask

  task automatic run_job(input string name, input int unsigned nt, input int unsigned ng,
                         input logic [63:0] ib, input logic [63:0] wb, input logic [63:0] ob,
                         input bit fast, input bit poke);
    int unsigned cyc = 0;
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      n_ifm[i] = 0; n_wgt[i] = 0; n_ofm[i] = 0; n_start[i] = 0; fin[i] = 0; conv_wait[i] = 0;
      in_comp[i] = 0; pf_chk[i] = 0; pf_exp[i] = 0; prev_start[i] = 0; rdy_last[i] = 0;
      hold_ifm[i] = 0; hold_wgt[i] = 0; hold_ofm[i] = 0; coll_chk[i] = 0;
      op_start[i] = 1'b1;
    end
    cfg_num_tiles = CW'(nt); cfg_co_groups = CW'(ng);
    ifm_base = ib; wgt_base = wb; ofm_base = ob;
    while (!(fin[0] && fin[1]) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      op_start[0] = 1'b0; op_start[1] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (!fin[i]) begin
          if (poke && cyc == 6) begin
            // Start attempt while busy, with config that would change every address.
            op_start[i] = 1'b1;
            cfg_num_tiles = CW'(nt + 1); ifm_base = ~ib; wgt_base = ~wb; ofm_base = ~ob;
          end
          step_dut(name, i, nt, ng, ib, wb, ob, fast, poke);
        end else if (coll_chk[i]) begin
          n_cmp++;
          if ({busy[i], ifm_req[i], wgt_req[i]} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s dut%0d start_on_done: got busy/ifm/wgt %b%b%b required 000", name, i,
                     busy[i], ifm_req[i], wgt_req[i]);
          end
          coll_chk[i] = 1'b0;
        end
      end
    end
    n_cmp++;
    if (!(fin[0] && fin[1])) begin
      n_fail++;
      $display("FAIL %s timeout: got done %b%b after %0d cycles required 11", name, fin[0], fin[1],
               cyc);
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      op_start[i] = 1'b0; end_conv[i] = 1'b0;
      ifm_done[i] = 1'b0; wgt_done[i] = 1'b0; ofm_done[i] = 1'b0;
      n_cmp++;
      if ({op_done[i], busy[i], ifm_req[i], wgt_req[i], ofm_req[i]} !== 5'b0) begin
        n_fail++;
        $display("FAIL %s dut%0d post_idle: got done/busy/reqs %b%b%b%b%b required 00000", name, i,
                 op_done[i], busy[i], ifm_req[i], wgt_req[i], ofm_req[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cfg_num_tiles = 16'd2; cfg_co_groups = 16'd1;
    ifm_base = 64'h1000; wgt_base = 64'h2000; ofm_base = 64'h3000;
    op_start[0] = 1'b1; op_start[1] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      op_start[i] = 1'b0; ifm_done[i] = 1'b1; wgt_done[i] = 1'b1;
      ifm_buf_rdy[i] = 1'b1; wgt_rdy[i] = 1'b1;
    end
    repeat (8) @(negedge clk);
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (busy[i] !== 1'b1) begin
        n_fail++; $display("FAIL reset dut%0d busy_in_compute: got %b required 1", i, busy[i]);
      end
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({ifm_req[i], wgt_req[i], ofm_req[i], start_conv[i], busy[i], op_done[i], ifm_addr[i],
           wgt_addr[i], ofm_addr[i], tile_idx[i], grp_idx[i]} !== '0) begin
        n_fail++;
        $display("FAIL reset dut%0d outputs_in_reset: got req %b%b%b busy %b addr %h required 0", i,
                 ifm_req[i], wgt_req[i], ofm_req[i], busy[i], ifm_addr[i]);
      end
    end
    rst_n = 1'b1;
    end_conv[0] = 1'b1; end_conv[1] = 1'b1; ofm_done[0] = 1'b1; ofm_done[1] = 1'b1;
    @(negedge clk);
    clear_inputs();
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if ({ifm_req[i], wgt_req[i], ofm_req[i], start_conv[i], busy[i], op_done[i]} !== 6'b0)
        begin
          n_fail++;
          $display("FAIL reset dut%0d after_release: got req %b%b%b start %b busy %b done %b "
                   , i, ifm_req[i], wgt_req[i], ofm_req[i], start_conv[i], busy[i], op_done[i],
                   "required all 0");
        end
      end
    end
  endtask

  task automatic test_single_tile;
    run_job("single", 1, 1, 64'h1000, 64'h2000, 64'h3000, 1'b1, 1'b0);
  endtask

  task automatic test_multi_tile;
    run_job("multi", 3, 2, 64'h10_0000, 64'h20_0000, 64'h40_0000, 1'b0, 1'b0);
  endtask

  task automatic test_prefetch;
    run_job("prefetch", 2, 1, 64'h8000, 64'h9000, 64'hA000, 1'b1, 1'b0);
    run_job("prefetch_slow", 3, 1, 64'h8000, 64'h9000, 64'hA000, 1'b0, 1'b0);
  endtask

  task automatic test_zero_cfg(input int unsigned nt, input int unsigned ng);
    logic [5:0] exp6;
    clear_inputs();
    cfg_num_tiles = CW'(nt); cfg_co_groups = CW'(ng);
    op_start[0] = 1'b1; op_start[1] = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      op_start[0] = 1'b0; op_start[1] = 1'b0;
      exp6 = (c == 2) ? 6'b100000 : 6'b000000;
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if ({op_done[i], busy[i], ifm_req[i], wgt_req[i], ofm_req[i], start_conv[i]} !== exp6)
        begin
          n_fail++;
          $display("FAIL zero_cfg(%0d,%0d) dut%0d cycle%0d: got done/busy/reqs/start %b%b%b%b%b%b required %b",
                   nt, ng, i, c, op_done[i], busy[i], ifm_req[i], wgt_req[i], ofm_req[i],
                   start_conv[i], exp6);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    run_job("b2b_poke", 2, 2, 64'hFFFF_FFFF_FFF0_0000, 64'h5000, 64'h6000, 1'b1, 1'b1);
    run_job("b2b_next", 1, 2, 64'h7000, 64'h7100, 64'h7200, 1'b1, 1'b0);
  endtask

  task automatic test_random;
    for (int j = 0; j < 6; j++) begin
      run_job("random", $urandom_range(1, 4), $urandom_range(1, 3), {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'($urandom_range(1)));
    end
  endtask

  initial begin
    clear_inputs();
    cfg_num_tiles = '0; cfg_co_groups = '0; ifm_base = '0; wgt_base = '0; ofm_base = '0;
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_prefetch();
    test_zero_cfg(0, 2);
    test_zero_cfg(3, 0);
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
